// File: rtl/bpu_predictor_pkg.sv
// Shared types and defaults for the branch predictor: counter encodings,
// redirect pulse levels and default geometry.
package bpu_predictor_pkg;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } bpu_cnt_e;

  localparam logic        BRANCH_ENABLE  = 1'b1;
  localparam logic        BRANCH_DISABLE = 1'b0;
  localparam int          BPU_ENTRIES    = 16;
  localparam logic [31:0] BPU_RESET_PC   = 32'h8000_0000;

endpackage

// File: rtl/bpu_predictor_if.sv
// Fetch-lookup, resolve-update and redirect signals between the pipeline
// (master) and the branch predictor (slave).
interface bpu_predictor_if #(
  parameter int XLEN = 32
);

  logic            fetch_valid_i;
  logic [XLEN-1:0] fetch_pc_i;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_npc_o;

  logic            resolve_valid_i;
  logic [XLEN-1:0] resolve_pc_i;
  logic            resolve_uncond_i;
  logic            resolve_taken_i;
  logic [XLEN-1:0] resolve_target_i;
  logic            resolve_pred_taken_i;
  logic [XLEN-1:0] resolve_pred_npc_i;

  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic [31:0]     mispred_cnt_o;

  modport master (
    output fetch_valid_i, fetch_pc_i,
    output resolve_valid_i, resolve_pc_i, resolve_uncond_i, resolve_taken_i,
    output resolve_target_i, resolve_pred_taken_i, resolve_pred_npc_i,
    input  pred_taken_o, pred_npc_o, redirect_o, redirect_pc_o, mispred_cnt_o
  );

  modport slave (
    input  fetch_valid_i, fetch_pc_i,
    input  resolve_valid_i, resolve_pc_i, resolve_uncond_i, resolve_taken_i,
    input  resolve_target_i, resolve_pred_taken_i, resolve_pred_npc_i,
    output pred_taken_o, pred_npc_o, redirect_o, redirect_pc_o, mispred_cnt_o
  );

endinterface

// File: rtl/bpu_sat_cnt2.sv
// Next-state function of a 2-bit saturating branch counter; force_st pins it
// to strongly-taken (unconditional jumps) regardless of the current state.
module bpu_sat_cnt2
  import bpu_predictor_pkg::*;
(
  input  bpu_cnt_e cnt,
  input  logic     taken,
  input  logic     force_st,
  output bpu_cnt_e cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt;
    if (force_st) begin
      cnt_nxt = CNT_ST;
    end else if (taken) begin
      case (cnt)
        CNT_SNT: cnt_nxt = CNT_WNT;
        CNT_WNT: cnt_nxt = CNT_WT;
        default: cnt_nxt = CNT_ST;
      endcase
    end else begin
      case (cnt)
        CNT_ST:  cnt_nxt = CNT_WT;
        CNT_WT:  cnt_nxt = CNT_WNT;
        default: cnt_nxt = CNT_SNT;
      endcase
    end
  end

endmodule

// File: rtl/bpu_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency next-PC prediction at
// fetch, training from resolved branches, and a registered one-cycle redirect.
module bpu_predictor
  import bpu_predictor_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              ENTRIES  = BPU_ENTRIES,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(BPU_RESET_PC)
) (
  input logic             clk,
  input logic             rst,
  bpu_predictor_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  bpu_cnt_e           cnt_q    [ENTRIES];

  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic [31:0]     mispred_cnt_q;

  // Fetch-side lookup reads the pre-update table contents.
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic             f_taken;

  assign f_idx   = bus.fetch_pc_i[IDX_W+1:2];
  assign f_tag   = bus.fetch_pc_i[XLEN-1:IDX_W+2];
  assign f_hit   = bus.fetch_valid_i && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_taken = !rst && f_hit && (cnt_q[f_idx] inside {CNT_WT, CNT_ST});

  assign bus.pred_taken_o = f_taken;
  assign bus.pred_npc_o   = rst     ? RESET_PC :
                            f_taken ? target_q[f_idx] : bus.fetch_pc_i + XLEN'(4);

  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;
  logic             r_alloc;
  logic [XLEN-1:0]  correct_npc;
  logic             mispredict;
  bpu_cnt_e         cnt_nxt;

  assign r_idx       = bus.resolve_pc_i[IDX_W+1:2];
  assign r_tag       = bus.resolve_pc_i[XLEN-1:IDX_W+2];
  assign r_hit       = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign r_alloc     = !r_hit && bus.resolve_taken_i;
  assign correct_npc = bus.resolve_taken_i ? bus.resolve_target_i
                                           : bus.resolve_pc_i + XLEN'(4);
  assign mispredict  = (bus.resolve_pred_taken_i != bus.resolve_taken_i) ||
                       (correct_npc != bus.resolve_pred_npc_i);

  bpu_sat_cnt2 u_sat_cnt2 (
    .cnt      (cnt_q[r_idx]),
    .taken    (bus.resolve_taken_i),
    .force_st (bus.resolve_uncond_i),
    .cnt_nxt  (cnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WNT;
      redirect_q    <= BRANCH_DISABLE;
      redirect_pc_q <= RESET_PC;
      mispred_cnt_q <= '0;
    end else begin
      redirect_q <= BRANCH_DISABLE;
      if (bus.resolve_valid_i) begin
        if (r_hit) begin
          cnt_q[r_idx] <= cnt_nxt;
        end else if (r_alloc) begin
          valid_q[r_idx] <= 1'b1;
          cnt_q[r_idx]   <= bus.resolve_uncond_i ? CNT_ST : CNT_WT;
        end
        // redirect_pc holds its last value between mispredicts.
        if (mispredict) begin
          redirect_q    <= BRANCH_ENABLE;
          redirect_pc_q <= correct_npc;
          mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
      end
    end
  end

  // Tags and targets are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (!rst && bus.resolve_valid_i && bus.resolve_taken_i) begin
      target_q[r_idx] <= bus.resolve_target_i;
      if (r_alloc) tag_q[r_idx] <= r_tag;
    end
  end

  assign bus.redirect_o    = redirect_q;
  assign bus.redirect_pc_o = redirect_pc_q;
  assign bus.mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_bpu_predictor.sv
// Directed bench for bpu_predictor: training, saturation, JALR targets,
// aliasing, same-cycle lookup/update and reset during a pending redirect.
module tb_bpu_predictor;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  bpu_predictor_if #(.XLEN(32)) bus ();

  bpu_predictor #(
    .XLEN     (32),
    .ENTRIES  (16),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_npc);
    bus.fetch_valid_i = 1'b1;
    bus.fetch_pc_i    = pc;
    #1;
    check({tag, "_taken"}, 32'(bus.pred_taken_o), 32'(exp_taken));
    check({tag, "_npc"}, bus.pred_npc_o, exp_npc);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic uncond, input logic taken,
                         input logic [31:0] target, input logic ptaken, input logic [31:0] pnpc);
    bus.resolve_valid_i      = 1'b1;
    bus.resolve_pc_i         = pc;
    bus.resolve_uncond_i     = uncond;
    bus.resolve_taken_i      = taken;
    bus.resolve_target_i     = target;
    bus.resolve_pred_taken_i = ptaken;
    bus.resolve_pred_npc_i   = pnpc;
    step();
    bus.resolve_valid_i      = 1'b0;
  endtask

  task automatic check_redirect(input string tag, input logic exp_vld,
                                input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
    check({tag, "_redir"}, 32'(bus.redirect_o), 32'(exp_vld));
    check({tag, "_redir_pc"}, bus.redirect_pc_o, exp_pc);
    check({tag, "_mispred_cnt"}, bus.mispred_cnt_o, exp_cnt);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.fetch_valid_i        = 1'b0;
    bus.fetch_pc_i           = '0;
    bus.resolve_valid_i      = 1'b0;
    bus.resolve_pc_i         = '0;
    bus.resolve_uncond_i     = 1'b0;
    bus.resolve_taken_i      = 1'b0;
    bus.resolve_target_i     = '0;
    bus.resolve_pred_taken_i = 1'b0;
    bus.resolve_pred_npc_i   = '0;
    step();
    step();

    lookup("rst_lookup", 32'h8000_0010, 1'b0, 32'h8000_0000);
    check_redirect("rst", 1'b0, 32'h8000_0000, 0);
    rst = 1'b0;
    lookup("cold_lookup", 32'h8000_0010, 1'b0, 32'h8000_0014);
    step();
    check_redirect("idle", 1'b0, 32'h8000_0000, 0);

    // Taken BEQ, first sighting: allocate with cnt=10.
    resolve(32'h8000_0010, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0014);
    check_redirect("beq_first", 1'b1, 32'h8000_0100, 1);
    lookup("beq_hit", 32'h8000_0010, 1'b1, 32'h8000_0100);
    step();
    check_redirect("beq_pulse_end", 1'b0, 32'h8000_0100, 1);

    // Not-taken twice: 10 -> 01 -> 00.
    resolve(32'h8000_0010, 1'b0, 1'b0, 32'h8000_0100, 1'b1, 32'h8000_0100);
    check_redirect("nt1", 1'b1, 32'h8000_0014, 2);
    lookup("nt1_lookup", 32'h8000_0010, 1'b0, 32'h8000_0014);
    resolve(32'h8000_0010, 1'b0, 1'b0, 32'h8000_0100, 1'b0, 32'h8000_0014);
    check_redirect("nt2", 1'b0, 32'h8000_0014, 2);
    resolve(32'h8000_0010, 1'b0, 1'b0, 32'h8000_0100, 1'b0, 32'h8000_0014);
    check_redirect("nt3_sat", 1'b0, 32'h8000_0014, 2);
    // 00 -> 01 still predicts not-taken; a second taken reaches 10.
    resolve(32'h8000_0010, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0014);
    check_redirect("t_after_sat", 1'b1, 32'h8000_0100, 3);
    lookup("cnt01_lookup", 32'h8000_0010, 1'b0, 32'h8000_0014);
    resolve(32'h8000_0010, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0014);
    check_redirect("t_again", 1'b1, 32'h8000_0100, 4);
    lookup("cnt10_lookup", 32'h8000_0010, 1'b1, 32'h8000_0100);

    // JALR: allocate strongly taken, then a target-only mispredict.
    resolve(32'h8000_0020, 1'b1, 1'b1, 32'h8000_0400, 1'b0, 32'h8000_0024);
    check_redirect("jalr_first", 1'b1, 32'h8000_0400, 5);
    lookup("jalr_hit", 32'h8000_0020, 1'b1, 32'h8000_0400);
    resolve(32'h8000_0020, 1'b1, 1'b1, 32'h8000_0800, 1'b1, 32'h8000_0400);
    check_redirect("jalr_tgt", 1'b1, 32'h8000_0800, 6);
    lookup("jalr_new_tgt", 32'h8000_0020, 1'b1, 32'h8000_0800);
    resolve(32'h8000_0020, 1'b1, 1'b1, 32'h8000_0800, 1'b1, 32'h8000_0800);
    check_redirect("jalr_correct", 1'b0, 32'h8000_0800, 6);

    // Aliasing: 0x50 shares index 4 with 0x10 and replaces it.
    resolve(32'h8000_0050, 1'b0, 1'b1, 32'h8000_0200, 1'b0, 32'h8000_0054);
    check_redirect("alias", 1'b1, 32'h8000_0200, 7);
    lookup("alias_old_miss", 32'h8000_0010, 1'b0, 32'h8000_0014);
    lookup("alias_new_hit", 32'h8000_0050, 1'b1, 32'h8000_0200);

    // Same-cycle lookup and first-time taken resolve of 0x30.
    bus.fetch_valid_i        = 1'b1;
    bus.fetch_pc_i           = 32'h8000_0030;
    bus.resolve_valid_i      = 1'b1;
    bus.resolve_pc_i         = 32'h8000_0030;
    bus.resolve_uncond_i     = 1'b0;
    bus.resolve_taken_i      = 1'b1;
    bus.resolve_target_i     = 32'h8000_0300;
    bus.resolve_pred_taken_i = 1'b0;
    bus.resolve_pred_npc_i   = 32'h8000_0034;
    #1;
    check("same_cyc_taken", 32'(bus.pred_taken_o), 32'd0);
    check("same_cyc_npc", bus.pred_npc_o, 32'h8000_0034);
    step();
    bus.resolve_valid_i = 1'b0;
    check_redirect("same_cyc", 1'b1, 32'h8000_0300, 8);
    lookup("next_cyc_hit", 32'h8000_0030, 1'b1, 32'h8000_0300);

    bus.fetch_valid_i = 1'b0;
    #1;
    check("no_fetch_taken", 32'(bus.pred_taken_o), 32'd0);
    check("no_fetch_npc", bus.pred_npc_o, 32'h8000_0034);
    lookup("wrap_npc", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // Reset on the same edge as a mispredicting resolve cancels the redirect.
    step();
    rst = 1'b1;
    resolve(32'h8000_0030, 1'b0, 1'b0, 32'h8000_0300, 1'b1, 32'h8000_0300);
    check_redirect("rst_cancel", 1'b0, 32'h8000_0000, 0);
    rst = 1'b0;
    lookup("post_rst_30", 32'h8000_0030, 1'b0, 32'h8000_0034);
    lookup("post_rst_50", 32'h8000_0050, 1'b0, 32'h8000_0054);
    lookup("post_rst_20", 32'h8000_0020, 1'b0, 32'h8000_0024);
    step();
    check_redirect("post_rst_idle", 1'b0, 32'h8000_0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
